// File: rtl/pipe_reg_hs.sv
// Valid/ready register-slice pipeline with collapsing bubbles, synchronous flush,
// occupancy reporting and saturating stall/flush statistics counters.
module pipe_reg_hs #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    output logic [DATA_W-1:0]          out_data_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic [CNT_W-1:0]           stall_cnt_o,
    output logic [CNT_W-1:0]           flush_cnt_o
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned LAST  = DEPTH - 1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  adv;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              out_xfer;

    // Flush masks the output so nothing leaves while the pipe is being emptied.
    assign out_valid_o = valid_q[LAST] & ~flush_i;
    assign out_data_o  = data_q[LAST];
    assign out_xfer    = out_valid_o & out_ready_i;
    assign in_ready_o  = adv[0] & ~flush_i & ~rst_i;
    assign occupancy_o = occ_q;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_cnt_q;

    // A slice may load when it is empty or its contents move on downstream.
    always_comb begin : adv_chain
        logic downstream;
        adv        = '0;
        downstream = out_xfer;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k]     = ~valid_q[k] | downstream;
            downstream = adv[k];
        end
    end

    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        stall_d     = stall_q;
        flush_cnt_d = flush_cnt_q;
        occ_d       = '0;

        if (flush_i) begin
            valid_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_d[k] = '0;
            end
        end else begin
            // Advancing with nothing incoming clears valid but keeps the stale payload.
            if (adv[0]) begin
                valid_d[0] = in_valid_i;
                if (in_valid_i) begin
                    data_d[0] = in_data_i;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k]) begin
                    valid_d[k] = valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_d[k] = data_q[k-1];
                    end
                end
            end
        end

        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end

        if (valid_q[LAST] && !out_ready_i && !flush_i && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (flush_i && (occ_q != '0) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            occ_q       <= '0;
            stall_q     <= '0;
            flush_cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            occ_q       <= occ_d;
            stall_q     <= stall_d;
            flush_cnt_q <= flush_cnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Directed bench for pipe_reg_hs: three instances (DEPTH 2, 4 and 1) driven from
// per-scenario tasks with hand-computed expectations.
module tb_pipe_reg_hs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: DEPTH=2, CNT_W=16
    logic       a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
    logic [7:0] a_in_data = 0, a_out_data;
    logic [1:0] a_occ;
    logic [15:0] a_stall, a_fcnt;

    // Instance B: DEPTH=4, CNT_W=4
    logic       b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
    logic [7:0] b_in_data = 0, b_out_data;
    logic [2:0] b_occ;
    logic [3:0] b_stall, b_fcnt;

    // Instance C: DEPTH=1, CNT_W=8
    logic       c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
    logic [7:0] c_in_data = 0, c_out_data;
    logic [0:0] c_occ;
    logic [7:0] c_stall, c_fcnt;

    pipe_reg_hs #(.DATA_W(8), .DEPTH(2), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .in_valid_i(a_in_valid),
        .in_data_i(a_in_data), .in_ready_o(a_in_ready), .out_valid_o(a_out_valid),
        .out_data_o(a_out_data), .out_ready_i(a_out_ready), .occupancy_o(a_occ),
        .stall_cnt_o(a_stall), .flush_cnt_o(a_fcnt));

    pipe_reg_hs #(.DATA_W(8), .DEPTH(4), .CNT_W(4)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .in_valid_i(b_in_valid),
        .in_data_i(b_in_data), .in_ready_o(b_in_ready), .out_valid_o(b_out_valid),
        .out_data_o(b_out_data), .out_ready_i(b_out_ready), .occupancy_o(b_occ),
        .stall_cnt_o(b_stall), .flush_cnt_o(b_fcnt));

    pipe_reg_hs #(.DATA_W(8), .DEPTH(1), .CNT_W(8)) u_c (
        .clk_i(clk), .rst_i(rst), .flush_i(c_flush), .in_valid_i(c_in_valid),
        .in_data_i(c_in_data), .in_ready_o(c_in_ready), .out_valid_o(c_out_valid),
        .out_data_o(c_out_data), .out_ready_i(c_out_ready), .occupancy_o(c_occ),
        .stall_cnt_o(c_stall), .flush_cnt_o(c_fcnt));

    task automatic test_reset();
        a_in_valid = 1; b_in_valid = 1; c_in_valid = 1;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_a_hs: out_valid=%b in_ready=%b exp 0 0", a_out_valid, a_in_ready); end
        checks++; if (a_occ !== 2'd0 || a_stall !== 16'd0 || a_fcnt !== 16'd0 || a_out_data !== 8'd0) begin errors++; $display("FAIL rst_a_regs: occ=%0d stall=%0d fcnt=%0d data=%h exp all 0", a_occ, a_stall, a_fcnt, a_out_data); end
        checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0 || b_occ !== 3'd0) begin errors++; $display("FAIL rst_b: out_valid=%b in_ready=%b occ=%0d exp 0 0 0", b_out_valid, b_in_ready, b_occ); end
        checks++; if (c_out_valid !== 1'b0 || c_in_ready !== 1'b0 || c_occ !== 1'd0) begin errors++; $display("FAIL rst_c: out_valid=%b in_ready=%b occ=%0d exp 0 0 0", c_out_valid, c_in_ready, c_occ); end
        a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
        @(negedge clk); @(negedge clk);
        rst = 0;
    endtask

    task automatic test_stream();
        logic exp_v;
        logic [7:0] exp_d;
        a_out_ready = 1;
        for (int i = 1; i <= 5; i++) begin
            a_in_valid = (i <= 3);
            a_in_data  = 8'hA0 + 8'(i);
            @(negedge clk);
            exp_v = (i >= 2 && i <= 4);
            exp_d = 8'hA0 + 8'(i - 1);
            checks++; if (a_out_valid !== exp_v || (exp_v && a_out_data !== exp_d)) begin errors++; $display("FAIL stream_edge%0d: valid=%b data=%h exp valid=%b data=%h", i, a_out_valid, a_out_data, exp_v, exp_d); end
        end
        checks++; if (a_occ !== 2'd0 || a_stall !== 16'd0) begin errors++; $display("FAIL stream_end: occ=%0d stall=%0d exp 0 0", a_occ, a_stall); end
    endtask

    task automatic test_backpressure();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 8'hB1; #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy1: in_ready=%b exp 1", a_in_ready); end
        @(negedge clk);
        a_in_data = 8'hB2; #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy2: in_ready=%b exp 1", a_in_ready); end
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hB1 || a_stall !== 16'd0) begin errors++; $display("FAIL bp_head: valid=%b data=%h stall=%0d exp 1 b1 0", a_out_valid, a_out_data, a_stall); end
        a_in_data = 8'hB3; #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy3: in_ready=%b exp 0", a_in_ready); end
        @(negedge clk);
        checks++; if (a_occ !== 2'd2 || a_stall !== 16'd1) begin errors++; $display("FAIL bp_full: occ=%0d stall=%0d exp 2 1", a_occ, a_stall); end
        @(negedge clk);
        checks++; if (a_stall !== 16'd2 || a_out_data !== 8'hB1) begin errors++; $display("FAIL bp_stall2: stall=%0d data=%h exp 2 b1", a_stall, a_out_data); end
        a_in_valid = 0; a_out_ready = 1;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hB2 || a_occ !== 2'd1) begin errors++; $display("FAIL bp_drain1: valid=%b data=%h occ=%0d exp 1 b2 1", a_out_valid, a_out_data, a_occ); end
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_stall !== 16'd2) begin errors++; $display("FAIL bp_drain2: valid=%b occ=%0d stall=%0d exp 0 0 2", a_out_valid, a_occ, a_stall); end
    endtask

    task automatic test_bubble();
        b_out_ready = 0;
        b_in_valid = 1; b_in_data = 8'h11;
        @(negedge clk);
        b_in_valid = 0;
        repeat (3) @(negedge clk);
        checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h11 || b_occ !== 3'd1 || b_stall !== 4'd0) begin errors++; $display("FAIL bub_head: valid=%b data=%h occ=%0d stall=%0d exp 1 11 1 0", b_out_valid, b_out_data, b_occ, b_stall); end
        b_in_valid = 1; b_in_data = 8'h55;
        @(negedge clk);
        b_in_valid = 0;
        repeat (2) @(negedge clk);
        checks++; if (b_occ !== 3'd2 || b_stall !== 4'd3 || b_out_data !== 8'h11) begin errors++; $display("FAIL bub_collapse: occ=%0d stall=%0d data=%h exp 2 3 11", b_occ, b_stall, b_out_data); end
        b_out_ready = 1;
        @(negedge clk);
        checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h55 || b_occ !== 3'd1) begin errors++; $display("FAIL bub_next: valid=%b data=%h occ=%0d exp 1 55 1", b_out_valid, b_out_data, b_occ); end
        b_out_ready = 0;
    endtask

    task automatic test_stall_sat();
        logic [3:0] exp_s;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp_s = (3 + i >= 15) ? 4'd15 : 4'(3 + i);
            checks++; if (b_stall !== exp_s) begin errors++; $display("FAIL stall_sat%0d: stall=%0d exp %0d", i, b_stall, exp_s); end
        end
    endtask

    task automatic test_flush();
        b_out_ready = 0;
        b_in_valid = 1; b_in_data = 8'h61;
        @(negedge clk);
        b_in_data = 8'h62;
        @(negedge clk);
        b_in_valid = 0;
        checks++; if (b_occ !== 3'd3 || b_out_data !== 8'h55) begin errors++; $display("FAIL fl_pre: occ=%0d data=%h exp 3 55", b_occ, b_out_data); end
        b_flush = 1; b_in_valid = 1; b_in_data = 8'h99; #1;
        checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0) begin errors++; $display("FAIL fl_mask: out_valid=%b in_ready=%b exp 0 0", b_out_valid, b_in_ready); end
        @(negedge clk);
        b_flush = 0; b_in_valid = 0; #1;
        checks++; if (b_out_valid !== 1'b0 || b_occ !== 3'd0 || b_fcnt !== 4'd1 || b_out_data !== 8'd0) begin errors++; $display("FAIL fl_one: valid=%b occ=%0d fcnt=%0d data=%h exp 0 0 1 00", b_out_valid, b_occ, b_fcnt, b_out_data); end
        b_flush = 1; b_in_valid = 1;
        repeat (3) @(negedge clk);
        checks++; if (b_occ !== 3'd0 || b_fcnt !== 4'd1) begin errors++; $display("FAIL fl_held: occ=%0d fcnt=%0d exp 0 1", b_occ, b_fcnt); end
        b_flush = 0; b_in_data = 8'h77; #1;
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL fl_resume_rdy: in_ready=%b exp 1", b_in_ready); end
        @(negedge clk);
        b_in_valid = 0;
        checks++; if (b_occ !== 3'd1 || b_fcnt !== 4'd1) begin errors++; $display("FAIL fl_resume: occ=%0d fcnt=%0d exp 1 1", b_occ, b_fcnt); end
    endtask

    task automatic test_depth1();
        c_out_ready = 1;
        for (int i = 1; i <= 3; i++) begin
            c_in_valid = 1; c_in_data = 8'hC0 + 8'(i); #1;
            checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL d1_rdy%0d: in_ready=%b exp 1", i, c_in_ready); end
            @(negedge clk);
            checks++; if (c_out_valid !== 1'b1 || c_out_data !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL d1_out%0d: valid=%b data=%h exp 1 %h", i, c_out_valid, c_out_data, 8'hC0 + 8'(i)); end
        end
        c_out_ready = 0; c_in_data = 8'hCF; #1;
        checks++; if (c_in_ready !== 1'b0) begin errors++; $display("FAIL d1_block: in_ready=%b exp 0", c_in_ready); end
        @(negedge clk);
        checks++; if (c_out_data !== 8'hC3 || c_stall !== 8'd1) begin errors++; $display("FAIL d1_hold: data=%h stall=%0d exp c3 1", c_out_data, c_stall); end
        c_out_ready = 1; #1;
        checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL d1_unblock: in_ready=%b exp 1", c_in_ready); end
        @(negedge clk);
        c_in_valid = 0;
        checks++; if (c_out_valid !== 1'b1 || c_out_data !== 8'hCF) begin errors++; $display("FAIL d1_cf: valid=%b data=%h exp 1 cf", c_out_valid, c_out_data); end
        @(negedge clk);
        checks++; if (c_out_valid !== 1'b0 || c_occ !== 1'd0) begin errors++; $display("FAIL d1_empty: valid=%b occ=%0d exp 0 0", c_out_valid, c_occ); end
    endtask

    task automatic test_reset_mid();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 8'h31;
        @(negedge clk);
        a_in_data = 8'h32;
        @(negedge clk);
        checks++; if (a_occ !== 2'd2 || a_stall === 16'd0) begin errors++; $display("FAIL rm_pre: occ=%0d stall=%0d exp 2 nonzero", a_occ, a_stall); end
        #2 rst = 1;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_occ !== 2'd0 || a_out_data !== 8'd0) begin errors++; $display("FAIL rm_async: valid=%b rdy=%b occ=%0d data=%h exp 0 0 0 00", a_out_valid, a_in_ready, a_occ, a_out_data); end
        checks++; if (a_stall !== 16'd0 || a_fcnt !== 16'd0) begin errors++; $display("FAIL rm_cnt: stall=%0d fcnt=%0d exp 0 0", a_stall, a_fcnt); end
        @(negedge clk);
        rst = 0; a_in_valid = 1; a_in_data = 8'h7E; a_out_ready = 1;
        @(negedge clk);
        a_in_valid = 0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rm_lat1: valid=%b exp 0", a_out_valid); end
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h7E) begin errors++; $display("FAIL rm_lat2: valid=%b data=%h exp 1 7e", a_out_valid, a_out_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t exp finish earlier", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_stall_sat();
        test_flush();
        test_depth1();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
